// File: rtl/regfile_wport_arbiter.sv
// Shares the register-file write port between pipeline writeback and a multi-cycle result FIFO.
// A busy-bit scoreboard drives the decode hazard stall; `define RF_ARB_BYPASS_EN adds forwarding outputs.
module regfile_wport_arbiter #(
  parameter int XLEN         = 32,
  parameter int QDEPTH       = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            wb_stall,
  input  logic            mc_valid,
  input  logic [4:0]      mc_rd,
  input  logic [XLEN-1:0] mc_data,
  output logic            mc_ready,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            hazard_stall,
`ifdef RF_ARB_BYPASS_EN
  output logic            fwd1_hit,
  output logic            fwd2_hit,
  output logic [XLEN-1:0] fwd_data,
`endif
  output logic            RegWriteW,
  output logic [4:0]      RdW,
  output logic [XLEN-1:0] ResultW
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [PW-1:0]   rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
  logic [PW:0]     count_q, count_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [31:0]     busy_q, busy_d;
  logic            regWrite_q, regWrite_d;
  logic [4:0]      rdW_q, rdW_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rdMem_q [QDEPTH];
  logic [XLEN-1:0] dataMem_q [QDEPTH];

  logic            wbValid, empty, full, forceFifo, fifoGrant, push;
  logic [4:0]      headRd;
  logic [XLEN-1:0] headData;
  logic [31:0]     busyView;

  // A starved FIFO overrides writeback; otherwise writeback wins and the FIFO takes idle slots.
  always_comb begin
    wbValid   = wb_we && (wb_rd != 5'd0);
    empty     = (count_q == '0);
    full      = (count_q == (PW+1)'(QDEPTH));
    headRd    = rdMem_q[rdPtr_q];
    headData  = dataMem_q[rdPtr_q];
    forceFifo = (starve_q == SW'(STARVE_LIMIT)) && !empty;
    fifoGrant = forceFifo || (!wbValid && !empty);
    push      = mc_valid && !full;
    wb_stall  = wbValid && fifoGrant;
    mc_ready  = !full;
  end

  always_comb begin
    rdPtr_d  = rdPtr_q;
    wrPtr_d  = wrPtr_q;
    count_d  = count_q;
    if (push)      wrPtr_d = wrPtr_q + 1'b1;
    if (fifoGrant) rdPtr_d = rdPtr_q + 1'b1;
    case ({push, fifoGrant})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    starve_d = (empty || fifoGrant) ? '0 : starve_q + 1'b1;
  end

  // Clear precedes set so that a same-cycle issue to the popped register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (fifoGrant && (headRd != 5'd0)) busy_d[headRd] = 1'b0;
    if (issue_valid && (issue_rd != 5'd0)) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    regWrite_d = 1'b0;
    rdW_d      = rdW_q;
    result_d   = result_q;
    if (fifoGrant) begin
      if (headRd != 5'd0) begin
        regWrite_d = 1'b1;
        rdW_d      = headRd;
        result_d   = headData;
      end
    end else if (wbValid) begin
      regWrite_d = 1'b1;
      rdW_d      = wb_rd;
      result_d   = wb_data;
    end
  end

  always_comb begin
    busyView = busy_q;
`ifdef RF_ARB_BYPASS_EN
    if (fifoGrant) busyView[headRd] = 1'b0;
`endif
    hazard_stall = ((rs1 != 5'd0) && busyView[rs1]) || ((rs2 != 5'd0) && busyView[rs2]);
  end

`ifdef RF_ARB_BYPASS_EN
  always_comb begin
    fwd1_hit = regWrite_q && (rdW_q == rs1) && (rdW_q != 5'd0);
    fwd2_hit = regWrite_q && (rdW_q == rs2) && (rdW_q != 5'd0);
    fwd_data = result_q;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      busy_q     <= '0;
      regWrite_q <= 1'b0;
      rdW_q      <= '0;
      result_q   <= '0;
    end else begin
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      busy_q     <= busy_d;
      regWrite_q <= regWrite_d;
      rdW_q      <= rdW_d;
      result_q   <= result_d;
    end
  end

  // Storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      rdMem_q[wrPtr_q]   <= mc_rd;
      dataMem_q[wrPtr_q] <= mc_data;
    end
  end

  assign RegWriteW = regWrite_q;
  assign RdW       = rdW_q;
  assign ResultW   = result_q;

endmodule
